// File: rtl/hit_judge_pkg.sv
// hit_judge_pkg: state encoding and default constants shared by the hit judge slice
package hit_judge_pkg;
  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;
  localparam int WINDOW = 8;
  localparam int HIT_PTS = 10;
  localparam int SCORE_W = 10;
  localparam int COMBO_MAX = 15;
  localparam int COMBO_W = $clog2(COMBO_MAX + 1);
endpackage

// File: rtl/hit_judge_if.sv
// hit_judge_if: song control, arrow/press pulses and judged results
interface hit_judge_if #(parameter int SCORE_W = hit_judge_pkg::SCORE_W);
  logic clr;
  logic arrow;
  logic press;
  logic hit;
  logic miss;
  logic [SCORE_W-1:0] score;
  logic [hit_judge_pkg::COMBO_W-1:0] combo;
  modport master(output clr, arrow, press, input hit, miss, score, combo);
  modport slave(input clr, arrow, press, output hit, miss, score, combo);
endinterface

// File: rtl/hit_judge_sat_counter.sv
// sat_counter: accumulator that adds INC when enabled and sticks at all-ones
module sat_counter #(
  parameter int W = 4,
  parameter int INC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  localparam logic [32:0] MAX = (33'd1 << W) - 33'd1;
  logic [32:0] sum;
  assign sum = 33'(q) + 33'(INC);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= sum > MAX ? MAX[W-1:0] : sum[W-1:0];
endmodule

// File: rtl/hit_judge.sv
// hit_judge: judges presses against a timing window after each arrow and keeps score/combo
module hit_judge #(
  parameter int WINDOW = hit_judge_pkg::WINDOW,
  parameter int HIT_PTS = hit_judge_pkg::HIT_PTS,
  parameter int SCORE_W = hit_judge_pkg::SCORE_W
) (
  input logic       clk,
  input logic       rst_n,
  hit_judge_if.slave bus
);
  import hit_judge_pkg::*;
  localparam logic [7:0] RELOAD = 8'(WINDOW - 1);
  state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  logic hit_q, miss_q, hit_d, miss_d, expired;
  assign expired = state == ARMED && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  // an arrow re-arms unless it is consumed by a simultaneous press from IDLE
  always_comb
    state_d = bus.clr ? IDLE
            : bus.arrow && (state == ARMED || !bus.press) ? ARMED
            : bus.press || expired ? IDLE
            : state;
  always_comb begin
    hit_d = !bus.clr && bus.press && (state == ARMED || bus.arrow);
    miss_d = !bus.clr && (bus.press ? state == IDLE && !bus.arrow
                                    : state == ARMED && (bus.arrow || cnt == '0));
    cnt_d = bus.clr ? '0
          : bus.arrow && state_d == ARMED ? RELOAD
          : state == ARMED && !bus.press && cnt != '0 ? cnt - 8'd1
          : cnt;
  end
  sat_counter #(.W(SCORE_W), .INC(HIT_PTS)) u_score (
    .clk(clk), .rst_n(rst_n), .clr(bus.clr), .en(hit_d), .q(bus.score)
  );
  sat_counter #(.W(COMBO_W), .INC(1)) u_combo (
    .clk(clk), .rst_n(rst_n), .clr(bus.clr || miss_d), .en(hit_d), .q(bus.combo)
  );
  assign bus.hit = hit_q;
  assign bus.miss = miss_q;
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: random and directed stimulus against a time-stamp model of the judge
module tb_hit_judge;
  localparam int WIN = 8;
  logic clk = 0, rst_n = 0, clr = 0, arrow = 0, press = 0;
  int checks = 0, errors = 0;
  logic pend;
  int ta, cyc, e_hit, e_miss, e_combo, e_s0, e_s1;
  hit_judge_if #(.SCORE_W(10)) b0();
  hit_judge_if #(.SCORE_W(4)) b1();
  assign b0.clr = clr;
  assign b0.arrow = arrow;
  assign b0.press = press;
  assign b1.clr = clr;
  assign b1.arrow = arrow;
  assign b1.press = press;
  hit_judge #(.WINDOW(WIN), .HIT_PTS(10), .SCORE_W(10)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  hit_judge #(.WINDOW(WIN), .HIT_PTS(10), .SCORE_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  // pending arrow remembered by its cycle stamp; it expires WIN cycles later
  always @(posedge clk or negedge rst_n) begin : model
    int nh, nm, nc, s0, s1, nta;
    logic np, ex;
    if (!rst_n) begin
      pend <= 0; ta <= 0; cyc <= 0; e_hit <= 0; e_miss <= 0; e_combo <= 0; e_s0 <= 0; e_s1 <= 0;
    end else begin
      np = pend; nta = ta; nh = 0; nm = 0; nc = e_combo; s0 = e_s0; s1 = e_s1;
      if (clr) begin
        np = 0; nc = 0; s0 = 0; s1 = 0;
      end else begin
        ex = pend && cyc == ta + WIN;
        nh = int'(press && (pend || arrow));
        nm = press ? int'(!(pend || arrow)) : int'(pend && (arrow || ex));
        if (nh != 0) begin
          nc = nc + 1 > 15 ? 15 : nc + 1;
          s0 = s0 + 10 > 1023 ? 1023 : s0 + 10;
          s1 = s1 + 10 > 15 ? 15 : s1 + 10;
        end
        if (nm != 0) nc = 0;
        if (arrow && (pend || !press)) begin
          np = 1; nta = cyc;
        end else if (press || ex) np = 0;
      end
      pend <= np; ta <= nta; cyc <= cyc + 1;
      e_hit <= nh; e_miss <= nm; e_combo <= nc; e_s0 <= s0; e_s1 <= s1;
    end
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      chk("hit0", int'(b0.hit), e_hit);
      chk("miss0", int'(b0.miss), e_miss);
      chk("score0", int'(b0.score), e_s0);
      chk("combo0", int'(b0.combo), e_combo);
      chk("hit1", int'(b1.hit), e_hit);
      chk("miss1", int'(b1.miss), e_miss);
      chk("score1", int'(b1.score), e_s1);
      chk("combo1", int'(b1.combo), e_combo);
    end
  task automatic step(input logic a, input logic p, input logic c);
    arrow = a; press = p; clr = c;
    @(posedge clk);
    @(negedge clk);
    arrow = 0; press = 0; clr = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask
  task automatic pulse_reset();
    rst_n = 0;
    #1;
    chk("rst_score", int'(b0.score), 0);
    chk("rst_combo", int'(b0.combo), 0);
    chk("rst_hit", int'(b0.hit), 0);
    chk("rst_miss", int'(b0.miss), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    #400000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("init_score", int'(b0.score), 0);
    chk("init_miss", int'(b0.miss), 0);
    step(1, 0, 0); idle(2); step(0, 1, 0);
    chk("late3_hit", int'(b0.hit), 1);
    chk("late3_score", int'(b0.score), 10);
    chk("late3_combo", int'(b0.combo), 1);
    chk("late3_model", e_s0, 10);
    step(1, 0, 0); idle(7);
    chk("expire_early", int'(b0.miss), 0);
    idle(1);
    chk("expire_miss", int'(b0.miss), 1);
    chk("expire_combo", int'(b0.combo), 0);
    chk("expire_model", e_miss, 1);
    step(0, 1, 0);
    chk("stray_miss", int'(b0.miss), 1);
    step(1, 1, 0);
    chk("same_hit", int'(b0.hit), 1);
    step(1, 0, 0); idle(7); step(0, 1, 0);
    chk("edge_hit", int'(b0.hit), 1);
    step(1, 0, 0); idle(8);
    chk("edge_miss", int'(b0.miss), 1);
    step(0, 1, 0);
    chk("edge_stray", int'(b0.miss), 1);
    chk("edge_nohit", int'(b0.hit), 0);
    step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
    chk("super_miss", int'(b0.miss), 1);
    idle(2); step(0, 1, 0);
    chk("super_hit", int'(b0.hit), 1);
    chk("super_combo", int'(b0.combo), 1);
    step(0, 0, 1);
    chk("clr_score1", int'(b1.score), 0);
    step(1, 1, 0);
    chk("sat_first", int'(b1.score), 10);
    step(1, 1, 0);
    chk("sat_second", int'(b1.score), 15);
    repeat (14) step(1, 1, 0);
    chk("combo16", int'(b0.combo), 15);
    step(1, 1, 0);
    chk("combo17", int'(b0.combo), 15);
    repeat (100) step(1, 1, 0);
    chk("score0_sat", int'(b0.score), 1023);
    step(1, 0, 0); idle(4);
    pulse_reset();
    idle(12);
    chk("post_rst_miss", int'(b0.miss), 0);
    step(1, 1, 0); step(1, 0, 0); idle(4); step(0, 0, 1);
    chk("clr_score", int'(b0.score), 0);
    chk("clr_combo", int'(b0.combo), 0);
    chk("clr_miss", int'(b0.miss), 0);
    idle(10);
    chk("post_clr_miss", int'(b0.miss), 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter WINDOW, default 8: number of cycles after an arrow pulse during which a press counts as a hit; legal range 1..255.
REQ-002 Parameter HIT_PTS, default 10: points added to score per hit.
REQ-003 Parameter SCORE_W, default 10: score width in bits.
REQ-004 Clock  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 clr  input  1  synchronous clear; starts a new song.
REQ-007 arrow  input  1  one-cycle pulse: an arrow has reached the target line.
REQ-008 press  input  1  one-cycle press pulse from the upstream press-conditioning stage (one pulse per physical press).
REQ-009 hit  output  1  registered one-cycle pulse: press judged on time.
REQ-010 miss  output  1  registered one-cycle pulse: arrow expired, arrow superseded, or stray press.
REQ-011 score  output  SCORE_W  accumulated points.
REQ-012 combo  output  4  consecutive hits since the last miss.

Function
REQ-013 The FSM has states IDLE (no arrow pending) and ARMED (window open); an internal down-counter cnt, 8 bits wide, tracks the window.
REQ-014 In IDLE: arrow&press -> hit, stay IDLE; arrow only -> ARMED, cnt<=WINDOW-1; press only -> miss (stray), stay IDLE; neither -> no change.
REQ-015 In ARMED with press: hit; if arrow in the same cycle -> stay ARMED, cnt<=WINDOW-1; else -> IDLE.
REQ-016 In ARMED with arrow and no press: miss for the old arrow; stay ARMED, cnt<=WINDOW-1.
REQ-017 In ARMED with neither: if cnt==0 -> miss, go to IDLE; else cnt<=cnt-1.
REQ-018 Window timing: for an arrow at cycle t, a press in cycles t+1..t+WINDOW is a hit; with no press, miss asserts in cycle t+WINDOW+1.
REQ-019 hit and miss are registered and assert in the cycle after the deciding input; they are never both high.
REQ-020 score updates on the same edge that asserts hit; score reads the new value while hit is high.
REQ-021 On each hit, score <= min(score+HIT_PTS, 2^SCORE_W-1), saturating and never wrapping; a miss leaves score unchanged.
REQ-022 On each hit, combo <= min(combo+1, 15); on each miss, combo <= 0; combo updates on the same edge as hit/miss.
REQ-023 clr=1 forces: state to IDLE, cnt to 0, hit to 0, miss to 0, score to 0, combo to 0 at the next edge; it overrides arrow/press in that cycle.
REQ-024 Inputs are assumed synchronous to Clock; the block does not synchronise or edge-detect them.

Reset
REQ-025 reset=0 asynchronously forces: state to IDLE, cnt to 0, hit to 0, miss to 0, score to 0, combo to 0; a pending arrow is discarded with no miss.
REQ-026 After reset deasserts, the first edge evaluates inputs per REQ-014.

Structure
REQ-027 A shared package holds the state encoding (IDLE=0, ARMED=1) and the default constants WINDOW, HIT_PTS, SCORE_W, and COMBO_MAX=15.
REQ-028 One sub-module, sat_counter (parameterised width and increment, with synchronous clear and saturate-at-max), is instantiated for both score and combo.
REQ-029 The FSM and window counter live in hit_judge itself.

Verification
REQ-030 arrow at t, press at t+3 (WINDOW=8) -> hit at t+4, score 0->10, combo 0->1, no miss.
REQ-031 arrow at t, no press -> miss exactly at t+9, combo cleared; a press at t+9 -> second miss (stray) at t+10.
REQ-032 arrow and press same cycle from IDLE -> hit next cycle; press at t+8 after arrow at t -> hit (window edge); press at t+9 -> miss.
REQ-033 arrows at t and t+2, press at t+5 -> miss at t+3 (first arrow superseded), hit at t+6; combo reads 1.
REQ-034 SCORE_W=4, HIT_PTS=10: two hits -> score 10 then 15 (saturated); 16 consecutive hits -> combo holds at 15.
REQ-035 Take reset low while ARMED with cnt=3 -> outputs zero immediately, no miss after release; clr mid-window -> same outcome one edge later.
